// File: rtl/seq_comparator_pkg.sv
// Shared types and sizing helpers for the sliced magnitude comparator.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } result_t;

  function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // A single-slice compare still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_comparator_if.sv
// Start/busy/done handshake plus operands and result flags of the comparator.
interface seq_comparator_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, gt, lt, eq
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, gt, lt, eq
  );
endinterface

// File: rtl/seq_comparator_slice_compare.sv
// One-slice magnitude compare; one-hot gt/lt/eq, optionally two's-complement.
module slice_compare #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             is_signed,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  always_comb begin
    eq = (x == y);
    if (is_signed) gt = ($signed(x) > $signed(y));
    else           gt = (x > y);
    lt = !eq && !gt;
  end
endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle wide comparator: walks slices MSB-first, stops at the first difference.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  seq_comparator_if.slave bus
);
  localparam int unsigned NUM_SLICES = num_slices(WIDTH, SLICE);
  localparam int unsigned IW         = idx_width(NUM_SLICES);

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("seq_comparator: WIDTH must be a multiple of SLICE");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [IW-1:0]    idx;
  result_t          res_q, cmp;
  logic [SLICE-1:0] sa, sb;
  logic             load, finish;

  always_comb begin
    sa = '0;
    sb = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (idx == IW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
  end

  slice_compare #(.SLICE(SLICE)) u_slice (
    .x        (sa),
    .y        (sb),
    .is_signed(mode_q && (idx == IW'(NUM_SLICES - 1))),
    .gt       (cmp.gt),
    .lt       (cmp.lt),
    .eq       (cmp.eq)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (!cmp.eq || idx == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = COMPARE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      idx    <= '0;
      res_q  <= '0;
    end else begin
      if (load) begin
        a_q    <= bus.a;
        b_q    <= bus.b;
        mode_q <= bus.signed_mode;
        idx    <= IW'(NUM_SLICES - 1);
      end else if (state == COMPARE && !finish) begin
        idx <= idx - IW'(1);
      end
      // Slice result is already one-hot, so it is the final result as-is.
      if (finish) res_q <= cmp;
    end
  end

  assign bus.busy = (state == COMPARE);
  assign bus.done = (state == DONE);
  assign bus.gt   = res_q.gt;
  assign bus.lt   = res_q.lt;
  assign bus.eq   = res_q.eq;

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator against a full-width reference compare.
module tb_seq_comparator;
  localparam int W  = 64;
  localparam int S  = 16;
  localparam int NS = W / S;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  seq_comparator_if #(.WIDTH(W)) bus();

  seq_comparator #(.WIDTH(W), .SLICE(S)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic mode);
    if (a == b) return 3'b001;
    if (mode) return ($signed(a) > $signed(b)) ? 3'b100 : 3'b010;
    return (a > b) ? 3'b100 : 3'b010;
  endfunction

  function automatic int model_k(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int s = NS - 1; s >= 0; s--)
      if (a[s*S +: S] != b[s*S +: S]) return NS - s;
    return NS;
  endfunction

  // Issues one compare and returns at the negedge where done is seen.
  task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                            output int busy_cnt, output logic [2:0] res, output bit timeout);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.signed_mode = mode;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    timeout  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin timeout = 1'b0; break; end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    res = {bus.gt, bus.lt, bus.eq};
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++; $display("FAIL reset_handshake busy/done got %b exp 00", {bus.busy, bus.done});
    end
    tests++;
    if ({bus.gt, bus.lt, bus.eq} !== 3'b000) begin
      fails++; $display("FAIL reset_result gt/lt/eq got %b exp 000", {bus.gt, bus.lt, bus.eq});
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] av [4] = '{64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0000,
                             64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_0001};
    logic [W-1:0] bv [4] = '{64'h0123_4567_89AB_CDEF, 64'h7FFF_FFFF_FFFF_FFFF,
                             64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_0002};
    logic         mv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]   er [4] = '{3'b001, 3'b100, 3'b010, 3'b010};
    int           ek [4] = '{4, 1, 1, 4};
    int cnt; logic [2:0] res; bit to;
    for (int i = 0; i < 4; i++) begin
      do_compare(av[i], bv[i], mv[i], cnt, res, to);
      tests++;
      if (to) begin fails++; $display("FAIL directed%0d_timeout no done seen", i); end
      tests++;
      if (res !== er[i]) begin
        fails++; $display("FAIL directed%0d_result got %b exp %b", i, res, er[i]);
      end
      tests++;
      if (cnt != ek[i]) begin
        fails++; $display("FAIL directed%0d_busy_cycles got %0d exp %0d", i, cnt, ek[i]);
      end
      @(negedge clk);
      tests++;
      if (bus.done !== 1'b0) begin
        fails++; $display("FAIL directed%0d_done_pulse got %b exp 0", i, bus.done);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b; logic mode; int s, cnt; logic [2:0] res; bit to;
    logic [S-1:0] nz;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      b = a;
      s = $urandom_range(0, NS);
      if (s < NS) begin
        nz = S'($urandom_range(1, (1 << S) - 1));
        b[s*S +: S] = b[s*S +: S] ^ nz;
        for (int j = 0; j < s; j++) b[j*S +: S] = S'($urandom);
      end
      mode = 1'($urandom_range(0, 1));
      do_compare(a, b, mode, cnt, res, to);
      tests++;
      if (to || res !== model_res(a, b, mode) || cnt != model_k(a, b)) begin
        fails++;
        $display("FAIL random%0d a=%h b=%h m=%b got res=%b k=%0d exp res=%b k=%0d to=%0d",
                 n, a, b, mode, res, cnt, model_res(a, b, mode), model_k(a, b), to);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0; logic [2:0] res = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = {$urandom, $urandom} | 64'h1; bus.b = '0; bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin dones++; res = {bus.gt, bus.lt, bus.eq}; end
      @(negedge clk);
    end
    tests++;
    if (dones != 1) begin fails++; $display("FAIL busy_start_dones got %0d exp 1", dones); end
    tests++;
    if (res !== 3'b001) begin fails++; $display("FAIL busy_start_result got %b exp 001", res); end
  endtask

  task automatic test_reset_mid();
    int cnt, dones = 0; logic [2:0] res; bit to;
    logic [W-1:0] x;
    do_compare(64'h9, 64'h2, 1'b0, cnt, res, to);
    x = {$urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b1; bus.a = x; bus.b = x; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq} !== 5'b0) begin
      fails++; $display("FAIL reset_mid_outputs got %b exp 00000",
                        {bus.busy, bus.done, bus.gt, bus.lt, bus.eq});
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    tests++;
    if (dones != 0) begin fails++; $display("FAIL reset_mid_no_done got %0d exp 0", dones); end
    do_compare(64'h5, 64'h0005_0000_0000_0000, 1'b0, cnt, res, to);
    tests++;
    if (to || res !== 3'b010 || cnt != 1) begin
      fails++; $display("FAIL reset_mid_recover got res=%b k=%0d to=%0d exp res=010 k=1", res, cnt, to);
    end
  endtask

  task automatic test_back_to_back();
    int t1 = 0, t2 = 0; bit seen;
    logic [W-1:0] x = {$urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b1; bus.a = x; bus.b = x; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.a = 64'd5; bus.b = 64'd3;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.done) begin seen = 1'b1; t1 = cyc; end
      else @(negedge clk);
    end
    tests++;
    if (!seen || {bus.gt, bus.lt, bus.eq} !== 3'b001) begin
      fails++; $display("FAIL b2b_first got %b seen=%0d exp 001", {bus.gt, bus.lt, bus.eq}, seen);
    end
    @(negedge clk);
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_no_idle busy got %b exp 1", bus.busy); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.done) begin seen = 1'b1; t2 = cyc; end
      else @(negedge clk);
    end
    tests++;
    if (!seen || t2 - t1 != 5) begin
      fails++; $display("FAIL b2b_spacing got %0d seen=%0d exp 5", t2 - t1, seen);
    end
    tests++;
    if ({bus.gt, bus.lt, bus.eq} !== 3'b100) begin
      fails++; $display("FAIL b2b_second got %b exp 100", {bus.gt, bus.lt, bus.eq});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised multi-cycle magnitude comparator for wide operands. It compares two WIDTH-bit values one SLICE-bit slice per clock, most significant slice first, and stops as soon as a slice differs. It supports unsigned and two's-complement signed modes under a start/busy/done handshake. It serves datapath blocks that need wide compares without a WIDTH-bit combinational compare chain.

## Interface
- WIDTH, 64, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 16, bits examined per cycle; NUM_SLICES = WIDTH/SLICE, and NUM_SLICES ≥ 1.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- start  input  1  request a compare; sampled on the rising edge.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- gt  output  1  A > B for the last completed compare.
- lt  output  1  A < B for the last completed compare.
- eq  output  1  A == B for the last completed compare.

## Operation
- FSM states: IDLE, COMPARE, DONE. All outputs come from registers or decode only the state; there is no combinational path from inputs to outputs.
- IDLE: if start = 1, capture a, b and signed_mode into internal registers, load the slice index with NUM_SLICES-1, and go to COMPARE. Otherwise stay in IDLE.
- COMPARE: compare slice[idx] of the captured A and B.
  - The top slice (idx = NUM_SLICES-1) is compared signed when signed_mode = 1.
  - All other slices are always compared unsigned.
  - If the slices differ, set gt or lt accordingly, clear the other two result bits, and go to DONE.
  - If the slices are equal and idx = 0, set eq = 1, clear gt and lt, and go to DONE.
  - If the slices are equal and idx > 0, decrement idx and stay in COMPARE.
- DONE: done = 1 for this cycle only.
  - If start = 1, capture new operands and go to COMPARE. Back-to-back compares are allowed.
  - Otherwise go to IDLE.
- busy = 1 exactly when the state is COMPARE.
- start is ignored while the state is COMPARE. The captured operands are not disturbed.
- gt, lt and eq update only on the edge that enters DONE, and hold until the next completed compare. After the first completion, exactly one of the three is high.
- Changes on a, b or signed_mode after capture have no effect on the running compare.
- NUM_SLICES = 1 is legal; every compare then takes exactly one COMPARE cycle.

## Timing
- Reset (n_rst = 0, asynchronous): state = IDLE, busy = 0, done = 0, gt = 0, lt = 0, eq = 0. Operand registers, mode register and index are all cleared.
- Reset asserted mid-compare aborts the compare immediately. No done pulse is produced and the previous result is lost.
- Latency: start is sampled at edge E0. The compare examines k slices at edges E1..Ek, where 1 ≤ k ≤ NUM_SLICES. done is high for the cycle following Ek.
  - Best case: k = 1 (top slices differ).
  - Worst case: k = NUM_SLICES (operands equal, or they differ only in slice 0).
- Throughput with back-to-back starts accepted in DONE: one compare per k+1 cycles.

## Structure
- Package seq_comparator_pkg holds:
  - the state enum type (IDLE, COMPARE, DONE);
  - a packed result type {gt, lt, eq};
  - a localparam function computing NUM_SLICES and the index width, $clog2(NUM_SLICES), with a minimum width of 1.
- One combinational sub-module, slice_compare, parameterised by SLICE.
  - Inputs: x, y and is_signed.
  - Outputs: one-hot gt, lt, eq.
  - Instantiated once and fed by an index-selected slice mux.
- The top level contains the FSM, the index counter, the capture registers and the result registers.
- Elaboration check: WIDTH % SLICE != 0 triggers $error.

## Test plan
All scenarios use the defaults WIDTH = 64, SLICE = 16.
- Equal operands: a = b = 0x0123_4567_89AB_CDEF, unsigned → busy for 4 cycles, then done pulse with eq = 1, gt = 0, lt = 0.
- Top-slice difference: a = 0x8000_0000_0000_0000, b = 0x7FFF_FFFF_FFFF_FFFF.
  - signed_mode = 0 → gt = 1 after 1 COMPARE cycle.
  - The same operands with signed_mode = 1 → lt = 1 after 1 COMPARE cycle.
- Bottom-slice difference: a = 0xFFFF_FFFF_FFFF_0001, b = 0xFFFF_FFFF_FFFF_0002, signed_mode = 1 → lt = 1 after 4 COMPARE cycles.
- Start pulsed and a, b changed while busy, with a = b = 0 captured → the new inputs are ignored, the result is eq = 1, and exactly one done pulse is produced.
- n_rst pulsed low during the 2nd COMPARE cycle → outputs go to 0 at once, no done pulse, and the next compare from IDLE completes normally.
- start held high through DONE with new operands 5 vs 3 (unsigned) → the next compare begins with no IDLE cycle, gt = 1, and the two done pulses are separated by 5 cycles.
